// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Round-robin grant, one operation per cycle, and a one-entry response
// register per requester with valid/ready handshakes on both sides.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_ctrl,
   input  logic [TAG_W-1:0] req0_tag,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_ctrl,
   input  logic [TAG_W-1:0] req1_tag,

   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_result,
   output logic             resp0_zero,
   output logic [TAG_W-1:0] resp0_tag,

   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_result,
   output logic             resp1_zero,
   output logic [TAG_W-1:0] resp1_tag,

   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);

   // Priority pointer: 0 favours requester 0 when both are eligible.
   logic             ptr_q, ptr_d;

   logic             resp0Valid_q, resp0Valid_d;
   logic [WIDTH-1:0] resp0Result_q, resp0Result_d;
   logic             resp0Zero_q, resp0Zero_d;
   logic [TAG_W-1:0] resp0Tag_q, resp0Tag_d;

   logic             resp1Valid_q, resp1Valid_d;
   logic [WIDTH-1:0] resp1Result_q, resp1Result_d;
   logic             resp1Zero_q, resp1Zero_d;
   logic [TAG_W-1:0] resp1Tag_q, resp1Tag_d;

   logic free0, free1;
   logic elig0, elig1;
   logic accept0, accept1;

   // Grant: a requester's ready depends on its own slot and on the other
   // requester's eligibility, but never on its own valid, so the two
   // readies can only both be high when neither side can collide.
   always_comb begin
      free0      = !resp0Valid_q || resp0_ready;
      free1      = !resp1Valid_q || resp1_ready;
      elig0      = req0_valid && free0;
      elig1      = req1_valid && free1;
      req0_ready = free0 && (!elig1 || (ptr_q == 1'b0));
      req1_ready = free1 && (!elig0 || (ptr_q == 1'b1));
      accept0    = req0_valid && req0_ready;
      accept1    = req1_valid && req1_ready;
   end

   // Drive the shared ALU from the winner; idle operands are zero so the
   // ALU inputs stay quiet when nobody is granted.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = 4'b0000;
      if (accept0) begin
         alu_a    = req0_a;
         alu_b    = req0_b;
         alu_ctrl = req0_ctrl;
      end else if (accept1) begin
         alu_a    = req1_a;
         alu_b    = req1_b;
         alu_ctrl = req1_ctrl;
      end
   end

   // Next state: a new accept loads the slot (even while it drains, so no
   // bubble); a drain alone clears valid but keeps the payload; the pointer
   // flips to favour the loser after every accept.
   always_comb begin
      ptr_d         = ptr_q;
      resp0Valid_d  = resp0Valid_q;
      resp0Result_d = resp0Result_q;
      resp0Zero_d   = resp0Zero_q;
      resp0Tag_d    = resp0Tag_q;
      resp1Valid_d  = resp1Valid_q;
      resp1Result_d = resp1Result_q;
      resp1Zero_d   = resp1Zero_q;
      resp1Tag_d    = resp1Tag_q;

      if (accept0) begin
         resp0Valid_d  = 1'b1;
         resp0Result_d = alu_out;
         resp0Zero_d   = alu_zero;
         resp0Tag_d    = req0_tag;
         ptr_d         = 1'b1;
      end else if (resp0_ready) begin
         resp0Valid_d  = 1'b0;
      end

      if (accept1) begin
         resp1Valid_d  = 1'b1;
         resp1Result_d = alu_out;
         resp1Zero_d   = alu_zero;
         resp1Tag_d    = req1_tag;
         ptr_d         = 1'b0;
      end else if (resp1_ready) begin
         resp1Valid_d  = 1'b0;
      end
   end

   // State registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q         <= 1'b0;
         resp0Valid_q  <= 1'b0;
         resp0Result_q <= '0;
         resp0Zero_q   <= 1'b0;
         resp0Tag_q    <= '0;
         resp1Valid_q  <= 1'b0;
         resp1Result_q <= '0;
         resp1Zero_q   <= 1'b0;
         resp1Tag_q    <= '0;
      end else begin
         ptr_q         <= ptr_d;
         resp0Valid_q  <= resp0Valid_d;
         resp0Result_q <= resp0Result_d;
         resp0Zero_q   <= resp0Zero_d;
         resp0Tag_q    <= resp0Tag_d;
         resp1Valid_q  <= resp1Valid_d;
         resp1Result_q <= resp1Result_d;
         resp1Zero_q   <= resp1Zero_d;
         resp1Tag_q    <= resp1Tag_d;
      end
   end

   assign resp0_valid  = resp0Valid_q;
   assign resp0_result = resp0Result_q;
   assign resp0_zero   = resp0Zero_q;
   assign resp0_tag    = resp0Tag_q;
   assign resp1_valid  = resp1Valid_q;
   assign resp1_result = resp1Result_q;
   assign resp1_zero   = resp1Zero_q;
   assign resp1_tag    = resp1Tag_q;

endmodule
